// File: rtl/secded_pkg.sv
// Shared SECDED definitions: codeword layout helpers and the scrubber FSM state type.
// Stored word is {hamming[N:1], p0}; parity at powers of two, data fills the rest in ascending order.
package secded_pkg;

  localparam int P0_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CHECK,
    WR,
    NEXT,
    DONE
  } state_e;

  // Smallest m with 2**m >= m + k + 1.
  function automatic int calc_m(input int k);
    int m;
    m = 1;
    while ((1 << m) < m + k + 1) m++;
    return m;
  endfunction

  function automatic logic is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data bit index held at non-power-of-two position p.
  function automatic int data_idx(input int p);
    return p - 1 - $clog2(p + 1);
  endfunction

  // Positions 1..n whose index has bit i set (parity group i).
  function automatic logic [63:0] cover_mask(input int i, input int n);
    logic [63:0] m;
    m = '0;
    for (int p = 1; p <= n; p++)
      if (((p >> i) & 1) != 0) m = m | (64'(1) << p);
    return m;
  endfunction

endpackage

// File: rtl/hamming_dec.sv
// Combinational SECDED decoder: syndrome + overall parity classify the word and correct data.
module hamming_dec
  import secded_pkg::*;
#(
  parameter  int K = 8,
  localparam int M = calc_m(K),
  localparam int N = M + K
) (
  input  logic [N:0]   cw,
  output logic [K-1:0] data,
  output logic         sb_err,
  output logic         db_err
);

  localparam logic [M-1:0] NMAX = M'(N);

  logic [M-1:0] syn;
  logic         par;
  logic         fix;

  for (genvar i = 0; i < M; i++) begin : g_syn
    localparam logic [63:0] CM = cover_mask(i, N);
    assign syn[i] = ^(cw & CM[N:0]);
  end

  assign par = ^cw;

  // Odd parity with a syndrome past N cannot be a single flip, so it is classed double.
  assign sb_err = par && (syn <= NMAX);
  assign db_err = (!par && (syn != '0)) || (par && (syn > NMAX));
  assign fix    = par && (syn != '0) && (syn <= NMAX);

  for (genvar p = 1; p <= N; p++) begin : g_out
    if (!is_pow2(p)) begin : g_dat
      assign data[data_idx(p)] = cw[p] ^ (fix && (syn == M'(p)));
    end
  end

endmodule

// File: rtl/hamming_enc.sv
// Combinational SECDED encoder: places data, computes Hamming parity, then overall parity p0.
module hamming_enc
  import secded_pkg::*;
#(
  parameter  int K = 8,
  localparam int M = calc_m(K),
  localparam int N = M + K
) (
  input  logic [K-1:0] data,
  output logic [N:0]   cw
);

  logic [N:1] dv;
  logic [N:1] h;

  for (genvar p = 1; p <= N; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par
      localparam logic [63:0] CM = cover_mask($clog2(p), N);
      assign dv[p] = 1'b0;
      assign h[p]  = ^(dv & CM[N:1]);
    end else begin : g_dat
      assign dv[p] = data[data_idx(p)];
      assign h[p]  = dv[p];
    end
  end

  assign cw[N:1]    = h;
  assign cw[P0_BIT] = ^h;

endmodule

// File: rtl/secded_scrubber.sv
// Walks 0..DEPTH-1 of a SECDED memory, rewrites single-bit errors and tallies double-bit errors.
module secded_scrubber
  import secded_pkg::*;
#(
  parameter  int K     = 8,
  parameter  int DEPTH = 16,
  parameter  int AW    = 4,
  parameter  int CW    = 8,
  localparam int M     = calc_m(K),
  localparam int N     = M + K
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [N:0]    mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [N:0]    mem_rdata_i,
  output logic [CW-1:0] sb_cnt_o,
  output logic [CW-1:0] db_cnt_o,
  output logic          db_flag_o,
  output logic [AW-1:0] db_addr_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e         state, state_nxt;
  logic [AW-1:0]  ptr;
  logic [N:0]     rword;
  logic [N:0]     enc_cw;
  logic [K-1:0]   fix_data;
  logic           sb_err, db_err;

  hamming_dec #(.K(K)) u_dec (
    .cw     (rword),
    .data   (fix_data),
    .sb_err (sb_err),
    .db_err (db_err)
  );

  hamming_enc #(.K(K)) u_enc (
    .data (fix_data),
    .cw   (enc_cw)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i)      state_nxt = RD_REQ;
      RD_REQ:  if (mem_gnt_i)    state_nxt = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i) state_nxt = CHECK;
      CHECK:   state_nxt = sb_err ? WR : NEXT;
      WR:      if (mem_gnt_i)    state_nxt = NEXT;
      NEXT:    state_nxt = (ptr == LAST) ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state != IDLE) && (state != DONE);
    done_o    = (state == DONE);
    mem_req_o = (state == RD_REQ) || (state == WR);
    mem_we_o  = (state == WR);
  end

  assign mem_addr_o = ptr;

  // Datapath; reset drops any in-flight write and ignores a late rvalid since state returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr         <= '0;
      rword       <= '0;
      mem_wdata_o <= '0;
      sb_cnt_o    <= '0;
      db_cnt_o    <= '0;
      db_flag_o   <= 1'b0;
      db_addr_o   <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_i) begin
          ptr       <= '0;
          sb_cnt_o  <= '0;
          db_cnt_o  <= '0;
          db_flag_o <= 1'b0;
          db_addr_o <= '0;
        end
        RD_WAIT: if (mem_rvalid_i) rword <= mem_rdata_i;
        CHECK: begin
          if (sb_err) begin
            if (sb_cnt_o != '1) sb_cnt_o <= sb_cnt_o + 1'b1;
            mem_wdata_o <= enc_cw;
          end
          if (db_err) begin
            if (db_cnt_o != '1) db_cnt_o <= db_cnt_o + 1'b1;
            if (!db_flag_o) begin
              db_flag_o <= 1'b1;
              db_addr_o <= ptr;
            end
          end
        end
        NEXT: if (ptr != LAST) ptr <= ptr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_scrubber.sv
// Bench for secded_scrubber: memory responder with random stalls, error-injection model, per-scenario checks.
module tb_secded_scrubber;

  localparam int K = 8, N = 12, DEPTH = 16, AW = 4, CW = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, req, we, db_flag;
  logic [AW-1:0] addr, db_addr;
  logic [N:0] wdata;
  logic [N:0] rdata = '0;
  logic gnt = 1'b0, rvalid = 1'b0;
  logic [CW-1:0] sb_cnt, db_cnt;

  always #5 clk = ~clk;

  secded_scrubber #(.K(K), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .sb_cnt_o(sb_cnt), .db_cnt_o(db_cnt), .db_flag_o(db_flag), .db_addr_o(db_addr)
  );

  int n_chk = 0, n_err = 0;
  logic [N:0] mem [DEPTH];
  logic [N:0] clean [DEPTH];
  logic [N:0] orig [DEPTH];
  int nflip [DEPTH];
  int max_stall = 0;
  bit wr_block = 0;
  int stall = 0, rd_wait = 0;
  bit rd_pend = 0, held = 0;
  logic [AW-1:0] rd_addr = '0, h_addr = '0;
  logic h_we = 1'b0;
  logic [N:0] h_wdata = '0;
  int rd_q[$], wr_a[$];
  logic [N:0] wr_d[$];
  int exp_sb, exp_db, exp_da, exp_wa[$];
  bit exp_flag;

  // Syndrome view of the code: parity bits make the XOR of all set positions zero.
  function automatic logic [N:0] enc(input logic [K-1:0] d);
    logic [N:0] c;
    int s, j;
    c = '0; s = 0; j = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        if (d[j]) begin c = c | (13'(1) << p); s = s ^ p; end
        j++;
      end
    for (int i = 0; i < 4; i++)
      if (((s >> i) & 1) != 0) c = c | (13'(1) << (1 << i));
    if (^c[N:1]) c[0] = 1'b1;
    return c;
  endfunction

  function automatic int dpos(input int j);
    int c, r;
    c = 0; r = -1;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        if (c == j) r = p;
        c++;
      end
    return r;
  endfunction

  function automatic void load(input int a, input logic [K-1:0] d, input int f0, input int f1);
    clean[a] = enc(d); mem[a] = clean[a]; nflip[a] = 0;
    if (f0 >= 0) begin mem[a] = mem[a] ^ (13'(1) << f0); nflip[a]++; end
    if (f1 >= 0) begin mem[a] = mem[a] ^ (13'(1) << f1); nflip[a]++; end
  endfunction

  // One flip is always correctable, two always detected; expected rewrite is the clean codeword.
  function automatic void model();
    exp_sb = 0; exp_db = 0; exp_da = 0; exp_flag = 0; exp_wa.delete();
    for (int a = 0; a < DEPTH; a++) begin
      if (nflip[a] == 1) begin exp_sb++; exp_wa.push_back(a); end
      else if (nflip[a] == 2) begin
        exp_db++;
        if (!exp_flag) begin exp_flag = 1; exp_da = a; end
      end
    end
  endfunction

  function automatic bit writes_ok();
    if (wr_a.size() != exp_wa.size()) return 0;
    foreach (exp_wa[i]) if (wr_a[i] != exp_wa[i] || wr_d[i] !== clean[exp_wa[i]]) return 0;
    return 1;
  endfunction

  function automatic bit reads_ok();
    if (rd_q.size() != DEPTH) return 0;
    foreach (rd_q[i]) if (rd_q[i] != i) return 0;
    return 1;
  endfunction

  function automatic bit mem_ok();
    for (int a = 0; a < DEPTH; a++) if (nflip[a] < 2 && mem[a] !== clean[a]) return 0;
    return 1;
  endfunction

  // Memory responder: decisions made on negedge so the DUT samples them at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      gnt = 0; rvalid = 0; rd_pend = 0; held = 0;
    end else begin
      rvalid = 0;
      if (rd_pend) begin
        if (rd_wait == 0) begin rvalid = 1; rdata = mem[rd_addr]; rd_pend = 0; end
        else rd_wait--;
      end
      if (held) begin
        n_chk++;
        if (!req || we !== h_we || addr !== h_addr || (h_we && wdata !== h_wdata)) begin
          n_err++;
          $display("FAIL req_stable got req=%b we=%b addr=%0d required req=1 we=%b addr=%0d", req, we, addr, h_we, h_addr);
        end
      end
      gnt = 0; held = 0;
      if (req && !rd_pend) begin
        if (stall > 0 || (we && wr_block)) begin
          if (stall > 0) stall--;
          held = 1; h_we = we; h_addr = addr; h_wdata = wdata;
        end else begin
          gnt = 1;
          if (we) begin wr_a.push_back(int'(addr)); wr_d.push_back(wdata); mem[addr] = wdata; end
          else begin rd_q.push_back(int'(addr)); rd_pend = 1; rd_addr = addr; rd_wait = $urandom_range(0, max_stall); end
          stall = $urandom_range(0, max_stall);
        end
      end
    end
  end

  task automatic run_pass(input bit poke, output bit to, output int dones, output logic busy0);
    rd_q.delete(); wr_a.delete(); wr_d.delete();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    busy0 = busy; to = 1; dones = 0;
    for (int c = 0; c < 3000; c++) begin
      if (poke) start = (c == 15);
      if (done) begin dones++; to = 0; break; end
      @(posedge clk); #1;
    end
    start = 0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (done) dones++; end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({busy, done, req, we} !== 4'b0) begin n_err++; $display("FAIL rst_ctrl got=%b required=0000", {busy, done, req, we}); end
    n_chk++; if (addr !== '0 || wdata !== '0) begin n_err++; $display("FAIL rst_mem got addr=%0d wdata=%h required 0 0", addr, wdata); end
    n_chk++; if (sb_cnt !== '0 || db_cnt !== '0 || db_flag !== 1'b0 || db_addr !== '0) begin n_err++; $display("FAIL rst_cnt got sb=%0d db=%0d flag=%b da=%0d required 0", sb_cnt, db_cnt, db_flag, db_addr); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_clean();
    bit to; int dones; logic b0;
    max_stall = 0;
    for (int a = 0; a < DEPTH; a++) load(a, 8'hA5, -1, -1);
    model();
    run_pass(0, to, dones, b0);
    n_chk++; if (to) begin n_err++; $display("FAIL clean_timeout got=timeout required=done"); end
    n_chk++; if (b0 !== 1'b1) begin n_err++; $display("FAIL clean_busy got=%b required=1", b0); end
    n_chk++; if (dones != 1) begin n_err++; $display("FAIL clean_done_pulse got=%0d required=1", dones); end
    n_chk++; if (!reads_ok()) begin n_err++; $display("FAIL clean_reads got=%0d reads required=%0d in order", rd_q.size(), DEPTH); end
    n_chk++; if (wr_a.size() != 0) begin n_err++; $display("FAIL clean_writes got=%0d required=0", wr_a.size()); end
    n_chk++; if (sb_cnt !== 8'd0 || db_cnt !== 8'd0 || db_flag !== 1'b0) begin n_err++; $display("FAIL clean_cnt got sb=%0d db=%0d flag=%b required 0 0 0", sb_cnt, db_cnt, db_flag); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL clean_idle got busy=%b required=0", busy); end
  endtask

  task automatic test_single();
    bit to; int dones; logic b0;
    max_stall = 0;
    for (int a = 0; a < DEPTH; a++) load(a, 8'hA5, (a == 5) ? dpos(3) : -1, -1);
    model();
    run_pass(0, to, dones, b0);
    n_chk++; if (to || dones != 1) begin n_err++; $display("FAIL single_done got to=%b dones=%0d required 0 1", to, dones); end
    n_chk++; if (wr_a.size() != 1 || wr_a[0] != 5 || wr_d[0] !== enc(8'hA5)) begin n_err++; $display("FAIL single_write got n=%0d required one write of %h to addr 5", wr_a.size(), enc(8'hA5)); end
    n_chk++; if (sb_cnt !== 8'd1 || db_cnt !== 8'd0) begin n_err++; $display("FAIL single_cnt got sb=%0d db=%0d required 1 0", sb_cnt, db_cnt); end
    n_chk++; if (!mem_ok()) begin n_err++; $display("FAIL single_mem got addr5=%h required=%h", mem[5], clean[5]); end
  endtask

  task automatic test_double();
    bit to; int dones; logic b0;
    max_stall = 0;
    for (int a = 0; a < DEPTH; a++) load(a, 8'hA5, (a == 2 || a == 9) ? 3 : -1, (a == 2) ? 0 : ((a == 9) ? 12 : -1));
    model();
    run_pass(0, to, dones, b0);
    n_chk++; if (to || dones != 1) begin n_err++; $display("FAIL double_done got to=%b dones=%0d required 0 1", to, dones); end
    n_chk++; if (wr_a.size() != 0) begin n_err++; $display("FAIL double_writes got=%0d required=0", wr_a.size()); end
    n_chk++; if (db_cnt !== 8'd2 || sb_cnt !== 8'd0) begin n_err++; $display("FAIL double_cnt got db=%0d sb=%0d required 2 0", db_cnt, sb_cnt); end
    n_chk++; if (db_flag !== 1'b1 || db_addr !== 4'd2) begin n_err++; $display("FAIL double_flag got flag=%b addr=%0d required 1 2", db_flag, db_addr); end
  endtask

  task automatic test_p0();
    bit to; int dones; logic b0;
    max_stall = 0;
    for (int a = 0; a < DEPTH; a++) load(a, 8'hA5, (a == 0) ? 0 : -1, -1);
    model();
    run_pass(0, to, dones, b0);
    n_chk++; if (to || dones != 1) begin n_err++; $display("FAIL p0_done got to=%b dones=%0d required 0 1", to, dones); end
    n_chk++; if (!writes_ok()) begin n_err++; $display("FAIL p0_write got n=%0d required one write of %h to addr 0", wr_a.size(), clean[0]); end
    n_chk++; if (sb_cnt !== 8'd1 || db_flag !== 1'b0) begin n_err++; $display("FAIL p0_cnt got sb=%0d flag=%b required 1 0", sb_cnt, db_flag); end
  endtask

  task automatic test_stall();
    bit to; int dones, nf, f0, f1; logic b0;
    logic [CW-1:0] sb0, db0;
    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < DEPTH; a++) begin
        nf = $urandom_range(0, 9);
        nf = (a == 7) ? 1 : ((nf < 6) ? 0 : ((nf < 8) ? 1 : 2));
        f0 = (nf >= 1) ? $urandom_range(0, N) : -1;
        f1 = (nf == 2) ? (f0 + 1 + $urandom_range(0, N - 1)) % (N + 1) : -1;
        load(a, K'($urandom), f0, f1);
        orig[a] = mem[a];
      end
      model();
      max_stall = 0;
      run_pass(0, to, dones, b0);
      sb0 = sb_cnt; db0 = db_cnt;
      for (int a = 0; a < DEPTH; a++) mem[a] = orig[a];
      max_stall = 5;
      run_pass(0, to, dones, b0);
      n_chk++; if (to || dones != 1) begin n_err++; $display("FAIL stall%0d_done got to=%b dones=%0d required 0 1", it, to, dones); end
      n_chk++; if (sb_cnt !== sb0 || db_cnt !== db0) begin n_err++; $display("FAIL stall%0d_vs_nostall got sb=%0d db=%0d required %0d %0d", it, sb_cnt, db_cnt, sb0, db0); end
      n_chk++; if (sb_cnt !== CW'(exp_sb) || db_cnt !== CW'(exp_db)) begin n_err++; $display("FAIL stall%0d_cnt got sb=%0d db=%0d required %0d %0d", it, sb_cnt, db_cnt, exp_sb, exp_db); end
      n_chk++; if (db_flag !== exp_flag || (exp_flag && db_addr !== AW'(exp_da))) begin n_err++; $display("FAIL stall%0d_flag got flag=%b addr=%0d required %b %0d", it, db_flag, db_addr, exp_flag, exp_da); end
      n_chk++; if (!writes_ok()) begin n_err++; $display("FAIL stall%0d_writes got=%0d required=%0d", it, wr_a.size(), exp_wa.size()); end
      n_chk++; if (!reads_ok() || !mem_ok()) begin n_err++; $display("FAIL stall%0d_reads_mem got reads=%0d required %0d and repaired memory", it, rd_q.size(), DEPTH); end
    end
    max_stall = 0;
  endtask

  task automatic test_reset_mid();
    bit to, seen; int dones; logic b0;
    max_stall = 0; wr_block = 1;
    for (int a = 0; a < DEPTH; a++) load(a, 8'hA5, (a == 5) ? 10 : -1, -1);
    model();
    rd_q.delete(); wr_a.delete(); wr_d.delete();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    seen = 0;
    for (int c = 0; c < 500; c++) begin
      if (req && we) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    n_chk++; if (!seen || addr !== 4'd5) begin n_err++; $display("FAIL rmid_wr_seen got seen=%b addr=%0d required 1 5", seen, addr); end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    n_chk++; if ({busy, done, req, we} !== 4'b0 || sb_cnt !== '0 || wdata !== '0) begin n_err++; $display("FAIL rmid_outputs got ctrl=%b sb=%0d wdata=%h required 0", {busy, done, req, we}, sb_cnt, wdata); end
    n_chk++; if (wr_a.size() != 0) begin n_err++; $display("FAIL rmid_no_write got=%0d required=0", wr_a.size()); end
    @(posedge clk); #1 rst = 0; wr_block = 0;
    run_pass(1, to, dones, b0);
    n_chk++; if (to || dones != 1) begin n_err++; $display("FAIL rmid_pass2_done got to=%b dones=%0d required 0 1", to, dones); end
    n_chk++; if (!reads_ok()) begin n_err++; $display("FAIL rmid_start_ignored got reads=%0d required %0d in order", rd_q.size(), DEPTH); end
    n_chk++; if (!writes_ok() || sb_cnt !== 8'd1) begin n_err++; $display("FAIL rmid_pass2 got writes=%0d sb=%0d required 1 1", wr_a.size(), sb_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_p0();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
